multicycle_control_fsm: RTL and testbench

Sequencing controller that turns the single-cycle MIPS datapath into a multicycle one sharing a single memory port for instruction fetch and data access. It decodes the opcode and funct fields of the latched instruction register and drives datapath mux selects, register/IR/PC write enables and a req/ready memory handshake, one state per cycle. It also counts retired instructions and halts on unsupported opcodes. It sits between the instruction register and the existing ALU control, register file, ALU and memory.

---
 rtl/multicycle_control_fsm.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller. It steps one state per cycle,
// decodes the opcode and funct fields held in the instruction register,
// drives the datapath selects and write enables, and runs a req/ready
// handshake on the shared memory port. It also counts retired
// instructions and parks in TRAP when it meets an unsupported opcode.
module multicycle_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 halted,
  output logic [3:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11,
    JAL    = 4'd12,
    JR     = 4'd13,
    TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t cur, nxt;

  // The branch decision is made in the datapath (pc_write_cond AND zero),
  // so the flag does not steer the sequence here.
  logic unused_zero;
  assign unused_zero = zero;

  // Next-state selection; memory states hold until the access completes.
  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                       nxt = MEMADR;
          OP_RTYPE:                           nxt = (funct == FN_JR) ? JR : REX;
          OP_BEQ:                             nxt = BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI:  nxt = IEX;
          OP_J:                               nxt = JUMP;
          OP_JAL:                             nxt = JAL;
          default:                            nxt = TRAP;
        endcase
      end
      MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) nxt = MEMWB;
      MEMWR:  if (mem_ready) nxt = FETCH;
      REX:    nxt = RWB;
      IEX:    nxt = IWB;
      MEMWB, RWB, BRANCH, IWB, JUMP, JAL, JR: nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end

  // State register and retirement counter; an instruction retires on the
  // edge that returns the sequence to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= FETCH;
      instret <= '0;
    end else begin
      cur <= nxt;
      if (nxt == FETCH && cur != FETCH)
        instret <= instret + INSTRET_W'(1);
    end
  end

  assign state = reset ? 4'd0 : cur;

  // Control decode from the current state; everything is held low in reset
  // so an outstanding memory request drops immediately.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    halted        = 1'b0;
    if (!reset) begin
      case (cur)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        MEMWR: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        RWB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = (opcode == OP_ORI || opcode == OP_LUI) ? 2'b11 : 2'b00;
        end
        IWB: reg_write = 1'b1;
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        JR: begin
          pc_write = 1'b1;
          pc_src   = 2'b11;
        end
        default: halted = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus a randomized
// instruction stream with random memory stalls, compared every cycle
// against an instruction-level reference model (per-opcode state plan,
// per-state control table, retirement count modulo 2^INSTRET_W).
module tb_multicycle_control_fsm;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opcode = 6'b0, funct = 6'b0;
  logic          zero = 1'b0, mem_ready = 1'b0;
  logic          mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic          alu_src_a, reg_write, halted;
  logic [3:0]    state;
  logic [IW-1:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_control_fsm #(.INSTRET_W(IW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            exp_state = 0;
  logic [IW-1:0] exp_instret = '0;
  int            plan[$];

  logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                           6'b001000, 6'b001001, 6'b001101, 6'b001111,
                           6'b000010, 6'b000011};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] outs_vec();
    return {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond,
            pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
            reg_write, halted};
  endfunction

  // Control word each phase of an instruction should present.
  function automatic logic [18:0] exp_outs(input int st, input logic [5:0] op, input logic rdy);
    logic mr, mw, io, irw, pcw, pcc, sa, rw, h;
    logic [1:0] ps, sb, ao, rd, m2r;
    {mr, mw, io, irw, pcw, pcc, sa, rw, h} = '0;
    {ps, sb, ao, rd, m2r} = '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mr = 1; mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin sa = 1; ao = 2'b01; pcc = 1; ps = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; ao = (op == 6'b001101 || op == 6'b001111) ? 2'b11 : 2'b00; end
      10: rw = 1;
      11: begin pcw = 1; ps = 2'b10; end
      12: begin pcw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      13: begin pcw = 1; ps = 2'b11; end
      default: h = 1;
    endcase
    return {mr, mw, io, irw, pcw, pcc, ps, sa, sb, ao, rd, m2r, rw, h};
  endfunction

  // Phases an instruction walks through after FETCH.
  task automatic load_plan(input logic [5:0] op, input logic [5:0] fn);
    plan.delete();
    case (op)
      6'b100011: plan = '{1, 2, 3, 4};
      6'b101011: plan = '{1, 2, 5};
      6'b000000: if (fn == 6'b001000) plan = '{1, 13}; else plan = '{1, 6, 7};
      6'b000100: plan = '{1, 8};
      6'b001000, 6'b001001, 6'b001101, 6'b001111: plan = '{1, 9, 10};
      6'b000010: plan = '{1, 11};
      6'b000011: plan = '{1, 12};
      default:   plan = '{1, 15};
    endcase
  endtask

  task automatic model_step(input logic rdy);
    if (exp_state == 0) begin
      if (rdy) begin
        load_plan(opcode, funct);
        exp_state = plan.pop_front();
      end
    end else if (exp_state == 15) begin
      exp_state = 15;
    end else if ((exp_state == 3 || exp_state == 5) && !rdy) begin
      exp_state = exp_state;
    end else if (plan.size() == 0) begin
      exp_state = 0;
      exp_instret = exp_instret + 1'b1;
    end else begin
      exp_state = plan.pop_front();
    end
  endtask

  // One clock: drive ready, compare mid-cycle, advance the model, then
  // return just after the next rising edge.
  task automatic cycle(input logic rdy);
    mem_ready = rdy;
    zero = 1'($urandom);
    @(negedge clk);
    check("state", 32'(state), 32'(exp_state));
    check("ctrl", 32'(outs_vec()), 32'(exp_outs(exp_state, opcode, rdy)));
    check("instret", 32'(instret), 32'(exp_instret));
    model_step(rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(outs_vec()), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("rst_ctrl_rdy", 32'(outs_vec()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    exp_state = 0;
    exp_instret = '0;
    plan.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [IW-1:0] base;
    do_reset();

    // R-type ADDU: FETCH, DECODE, REX, RWB
    opcode = 6'b000000; funct = 6'b100001;
    repeat (4) cycle(1'b1);
    check("rtype_retire", 32'(instret), 32'd1);
    check("rtype_state", 32'(state), 32'd0);

    // LW with two stalled MEMRD cycles: 7 cycles total
    base = exp_instret;
    opcode = 6'b100011;
    cycle(1'b1); cycle(1'b1); cycle(1'b1);
    cycle(1'b0); cycle(1'b0); cycle(1'b1);
    cycle(1'b1);
    check("lw_latency", 32'(instret), 32'(base + 1'b1));

    // BEQ, JAL, JR back to back with ready high
    opcode = 6'b000100; repeat (3) cycle(1'b1);
    opcode = 6'b000011; repeat (3) cycle(1'b1);
    opcode = 6'b000000; funct = 6'b001000; repeat (3) cycle(1'b1);

    // Reset in the middle of a stalled store
    opcode = 6'b101011;
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0);
    check("memwr_req_before", 32'({mem_req, mem_write}), 32'd3);
    do_reset();
    opcode = 6'b001101;
    cycle(1'b1); cycle(1'b1);

    // Finish that ORI, then illegal opcode -> TRAP that holds
    repeat (2) cycle(1'b1);
    opcode = 6'b111111;
    cycle(1'b1); cycle(1'b1);
    repeat (12) cycle(1'($urandom));
    check("trap_halted", 32'(halted), 32'd1);
    do_reset();
    check("trap_exit_halted", 32'(halted), 32'd0);

    // Random stream with random stalls; counter wraps at 2^IW
    repeat (600) begin
      if (exp_state == 0) begin
        opcode = ops[$urandom_range(0, 9)];
        funct = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      end
      cycle($urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
